ascon_round_sequencer: RTL and testbench

ASCON_ROUND_SEQUENCER -- requirements
Module: ascon_round_sequencer

---
 rtl/ascon_round_sequencer.sv | 123 ++++++++++++
 tb/tb_ascon_round_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_round_sequencer.sv
// rtl/ascon_round_sequencer.sv - Ascon permutation round sequencer (IDLE/RUN/DONE)
//
// Drives an external combinational datapath that evaluates HW_PERMUTATION_N
// rounds per cycle, iterating CLK_FACTOR times to complete the 12-round
// Ascon permutation.
//
// Optional feature macro: ASCON_SEQ_FLUSH_EN (adds flush_i, synchronous abort).
//
// Ports:
//   clk_i             rising-edge clock
//   rst_ni            asynchronous active-low reset
//   flush_i           (ASCON_SEQ_FLUSH_EN only) forces IDLE and clears state
//   valid_i/ready_o   upstream handshake, state_i captured on valid_i&&ready_o
//   state_i           320-bit input state
//   state_to_perm_o   state register, fed to the round datapath
//   round_index_o     round-group index for the datapath (0 outside RUN)
//   state_from_perm_i datapath result for the current group
//   valid_o/ready_i   downstream handshake for state_o
//   state_o           permuted result (the state register)
//   busy_o            high while in RUN or DONE

module ascon_round_sequencer #(
    parameter int HW_PERMUTATION_N = 6,
    parameter int CLK_FACTOR       = 2,
    // Index is 3 bits for every split up to 8 groups; the fully iterative
    // 1-round-per-cycle split needs indices up to 11 and widens to 4.
    localparam int IDX_W = (CLK_FACTOR > 8) ? $clog2(CLK_FACTOR) : 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef ASCON_SEQ_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [319:0]     state_i,
    output logic [319:0]     state_to_perm_o,
    output logic [IDX_W-1:0] round_index_o,
    input  logic [319:0]     state_from_perm_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [319:0]     state_o,
    output logic             busy_o
);

    if (HW_PERMUTATION_N * CLK_FACTOR != 12) begin : g_bad_cfg
        $error("ascon_round_sequencer: HW_PERMUTATION_N*CLK_FACTOR must equal 12");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [IDX_W-1:0] LAST_GROUP = IDX_W'(CLK_FACTOR - 1);

    fsm_t             fsm_q, fsm_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [319:0]     st_q, st_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= S_IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        case (fsm_q)
            S_IDLE: begin
                if (valid_i) begin
                    st_d  = state_i;
                    cnt_d = '0;
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                st_d = state_from_perm_i;
                if (cnt_q == LAST_GROUP) begin
                    cnt_d = '0;
                    fsm_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                // Return to IDLE only; a new accept needs ready_o, which is
                // low in DONE, so back-to-back capture is impossible here.
                if (ready_i) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                cnt_d = '0;
            end
        endcase
`ifdef ASCON_SEQ_FLUSH_EN
        if (flush_i) begin
            fsm_d = S_IDLE;
            cnt_d = '0;
            st_d  = '0;
        end
`endif
    end

    assign ready_o         = (fsm_q == S_IDLE);
    assign valid_o         = (fsm_q == S_DONE);
    assign busy_o          = (fsm_q != S_IDLE);
    assign round_index_o   = (fsm_q == S_RUN) ? cnt_q : '0;
    assign state_to_perm_o = st_q;
    assign state_o         = st_q;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// tb/tb_ascon_round_sequencer.sv - self-checking bench for ascon_round_sequencer
module tb_ascon_round_sequencer;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic         ready_i;
    logic [319:0] state_i;
`ifdef ASCON_SEQ_FLUSH_EN
    logic         flush_i;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Ascon reference model ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        x2 = x2 ^ {56'h0, 4'(15 - i), 4'(i)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [319:0] perm_group(input logic [319:0] s, input int idx, input int n);
        logic [319:0] r;
        r = s;
        for (int j = 0; j < n; j++) r = ascon_round(r, idx * n + j);
        return r;
    endfunction

    function automatic logic [319:0] p12(input logic [319:0] s);
        logic [319:0] r;
        r = s;
        for (int j = 0; j < 12; j++) r = ascon_round(r, j);
        return r;
    endfunction

    // ---------------- DUTs: 6x2, 12x1, 1x12 ----------------
    logic         rdy6, val6, bsy6;
    logic [2:0]   ri6;
    logic [319:0] tp6, fp6, so6;
    logic         rdy12, val12, bsy12;
    logic [2:0]   ri12;
    logic [319:0] tp12, fp12, so12;
    logic         rdy1, val1, bsy1;
    logic [3:0]   ri1;
    logic [319:0] tp1, fp1, so1;

    assign fp6  = perm_group(tp6,  int'(ri6),  6);
    assign fp12 = perm_group(tp12, int'(ri12), 12);
    assign fp1  = perm_group(tp1,  int'(ri1),  1);

    ascon_round_sequencer #(.HW_PERMUTATION_N(6), .CLK_FACTOR(2)) u6 (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef ASCON_SEQ_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i), .ready_o(rdy6), .state_i(state_i),
        .state_to_perm_o(tp6), .round_index_o(ri6), .state_from_perm_i(fp6),
        .valid_o(val6), .ready_i(ready_i), .state_o(so6), .busy_o(bsy6));

    ascon_round_sequencer #(.HW_PERMUTATION_N(12), .CLK_FACTOR(1)) u12 (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef ASCON_SEQ_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i), .ready_o(rdy12), .state_i(state_i),
        .state_to_perm_o(tp12), .round_index_o(ri12), .state_from_perm_i(fp12),
        .valid_o(val12), .ready_i(ready_i), .state_o(so12), .busy_o(bsy12));

    ascon_round_sequencer #(.HW_PERMUTATION_N(1), .CLK_FACTOR(12)) u1 (
        .clk_i(clk), .rst_ni(rst_n),
`ifdef ASCON_SEQ_FLUSH_EN
        .flush_i(flush_i),
`endif
        .valid_i(valid_i), .ready_o(rdy1), .state_i(state_i),
        .state_to_perm_o(tp1), .round_index_o(ri1), .state_from_perm_i(fp1),
        .valid_o(val1), .ready_i(ready_i), .state_o(so1), .busy_o(bsy1));

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // c = cycles since the accept edge; cf = groups for this instance
    task automatic check_inst(input string nm, input int c, input int cf,
                              input logic v, input logic r, input logic b,
                              input logic [3:0] idx, input logic [319:0] so,
                              input logic [319:0] exp);
        if (c <= cf) begin
            chk($sformatf("%s c%0d round_index", nm, c), 320'(idx), 320'(c - 1));
            chk($sformatf("%s c%0d valid_o run", nm, c), 320'(v), 320'(0));
            chk($sformatf("%s c%0d busy_o run", nm, c), 320'(b), 320'(1));
        end else if (c == cf + 1) begin
            chk($sformatf("%s c%0d valid_o done", nm, c), 320'(v), 320'(1));
            chk($sformatf("%s c%0d state_o", nm, c), so, exp);
            chk($sformatf("%s c%0d ready_o done", nm, c), 320'(r), 320'(0));
        end else begin
            chk($sformatf("%s c%0d valid_o idle", nm, c), 320'(v), 320'(0));
            chk($sformatf("%s c%0d ready_o idle", nm, c), 320'(r), 320'(1));
        end
    endtask

    typedef struct {
        logic [319:0] s;
        logic [319:0] exp;
    } vec_t;

    vec_t vecs[4];

    logic [319:0] sa, sb, ta;

    initial begin
        vecs[0].s = 320'h0;
        vecs[1].s = {5{64'h0123456789abcdef}};
        vecs[2].s = {64'h8040_0c06_0000_0000, 64'h0, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h1};
        vecs[3].s = {64'hdead_beef_cafe_f00d, 64'h1111_2222_3333_4444,
                     64'h5555_6666_7777_8888, 64'h9999_aaaa_bbbb_cccc, 64'hdddd_eeee_ffff_0000};
        for (int i = 0; i < 4; i++) vecs[i].exp = p12(vecs[i].s);

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; state_i = '0;
`ifdef ASCON_SEQ_FLUSH_EN
        flush_i = 1'b0;
`endif
        #1;
        chk("reset ready_o", 320'(rdy6), 320'(1));
        chk("reset valid_o", 320'(val6), 320'(0));
        chk("reset busy_o", 320'(bsy6), 320'(0));
        chk("reset round_index", 320'(ri6), 320'(0));
        chk("reset state_o", so6, 320'h0);
        chk("reset state_o cf12", so1, 320'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // table-driven runs on all three configurations in parallel
        for (int v = 0; v < 4; v++) begin
            valid_i = 1'b1; state_i = vecs[v].s; ready_i = 1'b1;
            tick();
            valid_i = 1'b0;
            for (int c = 1; c <= 14; c++) begin
                check_inst($sformatf("v%0d n6", v),  c, 2,  val6,  rdy6,  bsy6,  {1'b0, ri6},  so6,  vecs[v].exp);
                check_inst($sformatf("v%0d n12", v), c, 1,  val12, rdy12, bsy12, {1'b0, ri12}, so12, vecs[v].exp);
                check_inst($sformatf("v%0d n1", v),  c, 12, val1,  rdy1,  bsy1,  ri1,          so1,  vecs[v].exp);
                tick();
            end
        end

        // backpressure with valid_i held high carrying a different state
        sa = vecs[3].s; ta = vecs[1].s;
        valid_i = 1'b1; state_i = sa; ready_i = 1'b0;
        tick();
        state_i = ta;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d valid_o", k), 320'(val6), 320'(1));
            chk($sformatf("bp%0d state_o", k), so6, p12(sa));
            chk($sformatf("bp%0d ready_o", k), 320'(rdy6), 320'(0));
            if (k < 4) tick();
        end
        ready_i = 1'b1;
        tick();
        chk("bp release ready_o", 320'(rdy6), 320'(1));
        chk("bp release valid_o", 320'(val6), 320'(0));
        chk("bp release no same-cycle accept", 320'(bsy6), 320'(0));
        chk("bp release state held", so6, p12(sa));
        tick();
        chk("next accept busy_o", 320'(bsy6), 320'(1));
        valid_i = 1'b0;
        tick(); tick();
        chk("next accept valid_o", 320'(val6), 320'(1));
        chk("next accept state_o", so6, p12(ta));
        tick();

        // asynchronous reset in the middle of a run
        sb = vecs[2].s;
        valid_i = 1'b1; state_i = sb;
        tick();
        valid_i = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid_o", 320'(val6), 320'(0));
        chk("async rst state_o", so6, 320'h0);
        chk("async rst ready_o", 320'(rdy6), 320'(1));
        chk("async rst busy_o", 320'(bsy6), 320'(0));
        chk("async rst round_index", 320'(ri6), 320'(0));
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post rst%0d valid_o", k), 320'(val6), 320'(0));
            chk($sformatf("post rst%0d busy_o", k), 320'(bsy6), 320'(0));
        end

`ifdef ASCON_SEQ_FLUSH_EN
        flush_i = 1'b1; valid_i = 1'b1; state_i = sa;
        tick();
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush idle busy_o", 320'(bsy6), 320'(0));
        chk("flush idle state_o", so6, 320'h0);
        valid_i = 1'b1; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        chk("flush pre valid_o", 320'(val6), 320'(1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush done valid_o", 320'(val6), 320'(0));
        chk("flush done ready_o", 320'(rdy6), 320'(1));
        chk("flush done state_o", so6, 320'h0);
        ready_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
